// File: rtl/isqrt_seq.sv
// Sequential integer square root, y = floor(sqrt(x)), one result bit per clock
// using the shift-subtract (digit-by-digit) method with a start/busy handshake.
module isqrt_seq #(
  parameter int IN_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IN_W-1:0]   x_bi,
  input  logic              start,
  output logic              busy_o,
  output logic              done_o,
  output logic [IN_W/2-1:0] y_bo
);

  localparam int OUT_W = IN_W / 2;
  localparam logic [IN_W-1:0] MASK_ONE  = IN_W'(1);
  localparam logic [IN_W-1:0] MASK_INIT = MASK_ONE << (IN_W - 2);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WORK = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IN_W-1:0]  rem_q, rem_d;
  logic [IN_W-1:0]  root_q, root_d;
  logic [IN_W-1:0]  mask_q, mask_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             done_q, done_d;
  logic [IN_W-1:0]  trial_s;

  // State and datapath registers; reset abandons any run in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      root_q  <= '0;
      mask_q  <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      mask_q  <= mask_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: accept a start in IDLE, one root bit per WORK cycle
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    root_d  = root_q;
    mask_d  = mask_q;
    y_d     = y_q;
    done_d  = 1'b0;
    trial_s = root_q | mask_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = x_bi;
          root_d  = '0;
          mask_d  = MASK_INIT;
          state_d = WORK;
        end else begin
          state_d = IDLE;
        end
      end
      WORK: begin
        if (rem_q >= trial_s) begin
          rem_d  = rem_q - trial_s;
          root_d = (root_q >> 1) | mask_q;
        end else begin
          root_d = root_q >> 1;
        end
        mask_d = mask_q >> 2;
        // mask reaching bit 0 is the last step; publish the root written this edge
        if (mask_q == MASK_ONE) begin
          state_d = IDLE;
          done_d  = 1'b1;
          y_d     = root_d[OUT_W-1:0];
        end else begin
          state_d = WORK;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy_o = (state_q == WORK);
  assign done_o = done_q;
  assign y_bo   = y_q;

endmodule

// File: tb/tb_isqrt_seq.sv
// Self-checking bench for isqrt_seq: vector table, handshake corner cases,
// and randomized radicands against a plain floor-sqrt reference.
module tb_isqrt_seq;

  logic        clk;
  logic        reset_n;
  logic [15:0] x_bi;
  logic        start;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  y_bo;

  int checks;
  int failures;

  isqrt_seq #(.IN_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .x_bi    (x_bi),
    .start   (start),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .y_bo    (y_bo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string     name;
    int        x;
    int        y;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: largest r with r*r <= x
  function automatic int ref_sqrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // One single-cycle start; reports root, latency, busy/y behaviour during WORK
  task automatic do_op(input int x, output int y, output int lat,
                       output int busy_bad, output int y_moved);
    logic [7:0] y_before;
    @(negedge clk);
    start = 1'b1;
    x_bi  = 16'(x);
    @(negedge clk);
    start = 1'b0;
    y_before = y_bo;
    lat = 0;
    busy_bad = 0;
    y_moved = 0;
    while (!done_o && lat < 20) begin
      if (!busy_o) busy_bad++;
      if (y_bo != y_before) y_moved++;
      @(negedge clk);
      lat++;
    end
    if (busy_o) busy_bad++;
    y = int'(y_bo);
  endtask

  vec_t vecs[$];
  int y, lat, busy_bad, y_moved, bad, cyc, d1c, d2c, y1, y2, nd, a, b, x;

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    start = 1'b0;
    x_bi = 16'd0;

    a = 13;
    b = 13;
    vecs.push_back('{"sq144",  144,   12});
    vecs.push_back('{"ns143",  143,   11});
    vecs.push_back('{"zero",   0,     0});
    vecs.push_back('{"one",    1,     1});
    vecs.push_back('{"max",    65535, 255});
    vecs.push_back('{"sq65025",65025, 255});
    vecs.push_back('{"ns65024",65024, 254});
    vecs.push_back('{"mul13x13", a * b, 13});
    vecs.push_back('{"two",    2,     1});
    vecs.push_back('{"sq256",  256,   16});

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_y", int'(y_bo), 0);
    reset_n = 1'b1;

    // Table-driven vectors: root, latency, done width, busy and y stability
    foreach (vecs[i]) begin
      do_op(vecs[i].x, y, lat, busy_bad, y_moved);
      chk({vecs[i].name, "_y"}, y, vecs[i].y);
      chk({vecs[i].name, "_lat"}, lat, 8);
      chk({vecs[i].name, "_busy"}, busy_bad, 0);
      chk({vecs[i].name, "_ystable"}, y_moved, 0);
      @(negedge clk);
      chk({vecs[i].name, "_donewidth"}, int'(done_o), 0);
      chk({vecs[i].name, "_yhold"}, int'(y_bo), vecs[i].y);
    end

    // Reset during WORK: outputs clear at once and no done follows
    @(negedge clk);
    start = 1'b1;
    x_bi = 16'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_done", int'(done_o), 0);
    chk("midrst_y", int'(y_bo), 0);
    @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o || busy_o) bad++;
    end
    chk("midrst_nodone", bad, 0);

    // Start pulsed mid-run is ignored and x is not re-sampled
    @(negedge clk);
    start = 1'b1;
    x_bi = 16'd100;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    x_bi = 16'd9;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("midstart_y", int'(y_bo), 10);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_o) nd++;
    end
    chk("midstart_ignored", nd, 0);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1;
    x_bi = 16'd16;
    @(negedge clk);
    x_bi = 16'd81;
    cyc = 1;
    d1c = -1;
    d2c = -1;
    y1 = -1;
    y2 = -1;
    while (d2c < 0 && cyc < 40) begin
      if (done_o) begin
        if (d1c < 0) begin
          d1c = cyc;
          y1 = int'(y_bo);
        end else begin
          d2c = cyc;
          y2 = int'(y_bo);
          start = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("b2b_y1", y1, 4);
    chk("b2b_y2", y2, 9);
    chk("b2b_gap", d2c - d1c, 9);
    repeat (12) @(negedge clk);
    chk("b2b_stopped", int'(busy_o), 0);

    // Randomized radicands against the reference and the root bracket property
    for (int n = 0; n < 1000; n++) begin
      x = int'($urandom_range(0, 65535));
      do_op(x, y, lat, busy_bad, y_moved);
      chk("rand_y", y, ref_sqrt(x));
      chk("rand_bracket", int'((y * y <= x) && (x < (y + 1) * (y + 1))), 1);
      chk("rand_lat", lat, 8);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
